// File: rtl/mdl_ntt_seq_ctrl.sv
// Sequencing controller for a single radix-2 NTT/INTT butterfly unit.
// Produces operand, zeta and write-back addresses plus ping-pong bank selects; data muxing lives outside.
module mdl_ntt_seq_ctrl #(
    parameter int PRM_COEFFS = 256,
    parameter int PRM_ADDR   = 12,
    parameter int PRM_LAT    = 12,
    parameter int PRM_LOGCO  = $clog2(PRM_COEFFS)
) (
    input  logic                iSYS_CLK,
    input  logic                iSYS_RST,
    input  logic                iFSM_START,
    input  logic                iFSM_ABORT,
    input  logic                iCTL_SEL,
    input  logic [3:0]          iCTL_NTTDepth,
    input  logic                iHOLD,
    output logic                oFSM_BUSY,
    output logic                oFSM_DONE,
    output logic                oFSM_ERR,
    output logic                oRD_EN,
    output logic [PRM_ADDR-1:0] oRD_ADDRA,
    output logic [PRM_ADDR-1:0] oRD_ADDRB,
    output logic                oRD_BANK,
    output logic                oZeta_en,
    output logic [PRM_ADDR-1:0] oZeta_addr,
    output logic                oWR_EN,
    output logic [PRM_ADDR-1:0] oWR_ADDRA,
    output logic [PRM_ADDR-1:0] oWR_ADDRB,
    output logic                oWR_BANK,
    output logic                oRES_BANK
);

    localparam int AW = PRM_ADDR;
    localparam int JW = PRM_LOGCO - 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [4:0]    MAX_DEPTH = 5'(PRM_LOGCO);
    localparam logic [AW-1:0] HALF_N    = AW'(PRM_COEFFS / 2);
    localparam logic [5:0]    DRAIN_LD  = 6'(PRM_LAT - 1);

    logic [1:0]    state;
    logic          sel;
    logic [3:0]    depth;
    logic          errLat;
    logic [JW-1:0] jCnt;
    logic [3:0]    sCnt;
    logic [5:0]    drainCnt;
    logic          flipPend;

    logic          busy;
    logic          done;
    logic          err;
    logic          rdBank;
    logic          wrBank;
    logic          resBank;

    logic          rdEn_p0;
    logic [AW-1:0] rdA_p0;
    logic [AW-1:0] rdB_p0;
    logic [AW-1:0] zeta_p0;

    logic          wbVld_p1 [PRM_LAT];
    logic [AW-1:0] wbA_p1   [PRM_LAT];
    logic [AW-1:0] wbB_p1   [PRM_LAT];

    logic [4:0]    lgLen;
    logic [AW-1:0] jExt;
    logic [AW-1:0] lenV;
    logic [AW-1:0] grpV;
    logic [AW-1:0] ofsV;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [AW-1:0] zetaV;
    logic          depthOk;
    logic          jLast;
    logic          sLast;

    // Butterfly j of stage s: half-span len, group g = j/len, offset k = j%len.
    always_comb begin
        lgLen = sel ? {1'b0, sCnt} : (5'(PRM_LOGCO - 1) - {1'b0, sCnt});
        jExt  = AW'(jCnt);
        lenV  = AW'(1) << lgLen;
        grpV  = jExt >> lgLen;
        ofsV  = jExt & (lenV - AW'(1));
        addrA = (grpV << (lgLen + 5'd1)) | ofsV;
        addrB = addrA + lenV;
        zetaV = sel ? (((HALF_N >> sCnt) << 1) - AW'(2) - grpV)
                    : ((AW'(1) << sCnt) - AW'(1) + grpV);
    end

    assign depthOk = (iCTL_NTTDepth != 4'd0) && ({1'b0, iCTL_NTTDepth} <= MAX_DEPTH);
    assign jLast   = (jCnt == {JW{1'b1}});
    assign sLast   = (sCnt == (depth - 4'd1));

    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST || iFSM_ABORT) begin
            state    <= ST_IDLE;
            sel      <= 1'b0;
            depth    <= 4'd0;
            errLat   <= 1'b0;
            jCnt     <= '0;
            sCnt     <= 4'd0;
            drainCnt <= 6'd0;
            flipPend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdBank   <= 1'b0;
            wrBank   <= 1'b0;
            resBank  <= 1'b0;
            rdEn_p0  <= 1'b0;
            rdA_p0   <= '0;
            rdB_p0   <= '0;
            zeta_p0  <= '0;
            for (int i = 0; i < PRM_LAT; i++) begin
                wbVld_p1[i] <= 1'b0;
                wbA_p1[i]   <= '0;
                wbB_p1[i]   <= '0;
            end
        end else begin
            rdEn_p0 <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;

            // Write-back delay line: read issue re-emerges PRM_LAT cycles later.
            wbVld_p1[0] <= rdEn_p0;
            wbA_p1[0]   <= rdA_p0;
            wbB_p1[0]   <= rdB_p0;
            for (int i = 1; i < PRM_LAT; i++) begin
                wbVld_p1[i] <= wbVld_p1[i-1];
                wbA_p1[i]   <= wbA_p1[i-1];
                wbB_p1[i]   <= wbB_p1[i-1];
            end

            // Bank swap lands one cycle after the stage's last write so that write keeps its bank.
            if (flipPend) begin
                rdBank   <= ~rdBank;
                wrBank   <= ~wrBank;
                flipPend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (iFSM_START && !done) begin
                        sel    <= iCTL_SEL;
                        depth  <= iCTL_NTTDepth;
                        errLat <= ~depthOk;
                        jCnt   <= '0;
                        sCnt   <= 4'd0;
                        rdBank <= 1'b0;
                        wrBank <= 1'b1;
                        state  <= depthOk ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    busy <= 1'b1;
                    if (!iHOLD) begin
                        rdEn_p0 <= 1'b1;
                        rdA_p0  <= addrA;
                        rdB_p0  <= addrB;
                        zeta_p0 <= zetaV;
                        if (jLast) begin
                            jCnt     <= '0;
                            drainCnt <= DRAIN_LD;
                            state    <= ST_DRAIN;
                        end else begin
                            jCnt <= jCnt + JW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    busy <= 1'b1;
                    if (drainCnt == 6'd0) begin
                        flipPend <= 1'b1;
                        if (sLast) begin
                            state <= ST_DONE;
                        end else begin
                            sCnt  <= sCnt + 4'd1;
                            state <= ST_ISSUE;
                        end
                    end else begin
                        drainCnt <= drainCnt - 6'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    err     <= errLat;
                    resBank <= depth[0];
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign oFSM_BUSY  = busy;
    assign oFSM_DONE  = done;
    assign oFSM_ERR   = err;
    assign oRD_EN     = rdEn_p0;
    assign oRD_ADDRA  = rdA_p0;
    assign oRD_ADDRB  = rdB_p0;
    assign oRD_BANK   = rdBank;
    assign oZeta_en   = rdEn_p0;
    assign oZeta_addr = zeta_p0;
    assign oWR_EN     = wbVld_p1[PRM_LAT-1];
    assign oWR_ADDRA  = wbA_p1[PRM_LAT-1];
    assign oWR_ADDRB  = wbB_p1[PRM_LAT-1];
    assign oWR_BANK   = wrBank;
    assign oRES_BANK  = resBank;

endmodule

// File: tb/tb_mdl_ntt_seq_ctrl.sv
// Scoreboard bench for mdl_ntt_seq_ctrl (N=16, LAT=4): expected strobes are queued at launch
// and a negedge monitor pops and compares them whenever the DUT emits a read, write or DONE.
module tb_mdl_ntt_seq_ctrl;
    localparam int N    = 16;
    localparam int AW   = 12;
    localparam int L    = 4;
    localparam int LOGN = 4;
    localparam int H    = N / 2;
    localparam int BIG  = 1 << 30;

    logic          clk = 1'b0;
    logic          rst, start, abort, sel, hold;
    logic [3:0]    depth;
    logic          busy, done, err, rdEn, rdBank, zEn, wrEn, wrBank, resBank;
    logic [AW-1:0] rdA, rdB, zAddr, wrA, wrB;

    mdl_ntt_seq_ctrl #(.PRM_COEFFS(N), .PRM_ADDR(AW), .PRM_LAT(L)) dut (
        .iSYS_CLK(clk), .iSYS_RST(rst), .iFSM_START(start), .iFSM_ABORT(abort),
        .iCTL_SEL(sel), .iCTL_NTTDepth(depth), .iHOLD(hold),
        .oFSM_BUSY(busy), .oFSM_DONE(done), .oFSM_ERR(err),
        .oRD_EN(rdEn), .oRD_ADDRA(rdA), .oRD_ADDRB(rdB), .oRD_BANK(rdBank),
        .oZeta_en(zEn), .oZeta_addr(zAddr),
        .oWR_EN(wrEn), .oWR_ADDRA(wrA), .oWR_ADDRB(wrB), .oWR_BANK(wrBank),
        .oRES_BANK(resBank)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nTests = 0;
    int nFail  = 0;
    int lastT0 = 0;

    typedef struct { int cyc; int a; int b; int z; int bank; } ev_t;
    typedef struct { int cyc; int err; int res; } dn_t;
    typedef struct { int cyc; int wr; int a; int b; int z; int bank; } sp_t;

    ev_t rdQ[$];
    ev_t wrQ[$];
    dn_t dnQ[$];
    sp_t spQ[$];

    task automatic check(input string nm, input bit ok, input string act, input string req);
        nTests++;
        if (!ok) begin
            nFail++;
            $display("FAIL %s: got %s, expected %s", nm, act, req);
        end
    endtask

    // Reference NTT loop nest: groups of 2*len, zeta counter running up (forward) or down (inverse).
    task automatic pushModel(input int t0, input bit s, input int d, input int hAt, input int hLen, input int cut);
        int len, kz, jIdx, c;
        if (d < 1 || d > LOGN) begin
            if (1 < cut) dnQ.push_back('{t0 + 1, 1, -1});
            return;
        end
        kz = s ? N - 2 : 0;
        for (int st = 0; st < d; st++) begin
            len  = s ? (1 << st) : (H >> st);
            jIdx = 0;
            for (int base = 0; base < N; base += 2 * len) begin
                for (int k = base; k < base + len; k++) begin
                    c = 1 + st * (H + L) + jIdx;
                    if (hLen > 0 && c >= hAt) c += hLen;
                    if (c < cut)     rdQ.push_back('{t0 + c, k, k + len, kz, st % 2});
                    if (c + L < cut) wrQ.push_back('{t0 + c + L, k, k + len, 0, (st % 2) ^ 1});
                    jIdx++;
                end
                kz = s ? kz - 1 : kz + 1;
            end
        end
        c = d * (H + L) + 1 + hLen;
        if (c < cut) dnQ.push_back('{t0 + c, 0, d % 2});
    endtask

    task automatic addSpot(input int c, input int wr, input int a, input int b, input int z, input int bank);
        spQ.push_back('{c, wr, a, b, z, bank});
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        dn_t dn;
        sp_t p;
        while (spQ.size() > 0 && spQ[0].cyc <= cyc) begin
            p = spQ.pop_front();
            if (p.wr != 0)
                check("spot_wr", p.cyc == cyc && wrEn && wrA == p.a && wrB == p.b && wrBank == p.bank,
                      $sformatf("cyc=%0d en=%0d A=%0d B=%0d bank=%0d", cyc, wrEn, wrA, wrB, wrBank),
                      $sformatf("cyc=%0d en=1 A=%0d B=%0d bank=%0d", p.cyc, p.a, p.b, p.bank));
            else
                check("spot_rd", p.cyc == cyc && rdEn && rdA == p.a && rdB == p.b && rdBank == p.bank &&
                      (p.z < 0 || zAddr == p.z),
                      $sformatf("cyc=%0d en=%0d A=%0d B=%0d Z=%0d bank=%0d", cyc, rdEn, rdA, rdB, zAddr, rdBank),
                      $sformatf("cyc=%0d en=1 A=%0d B=%0d Z=%0d bank=%0d", p.cyc, p.a, p.b, p.z, p.bank));
        end
        if (rdEn) begin
            if (rdQ.size() == 0) check("rd_extra", 1'b0, $sformatf("read at cyc=%0d A=%0d", cyc, rdA), "no read");
            else begin
                e = rdQ.pop_front();
                check("rd", e.cyc == cyc && rdA == e.a && rdB == e.b && zAddr == e.z && rdBank == e.bank && zEn,
                      $sformatf("cyc=%0d A=%0d B=%0d Z=%0d bank=%0d zen=%0d", cyc, rdA, rdB, zAddr, rdBank, zEn),
                      $sformatf("cyc=%0d A=%0d B=%0d Z=%0d bank=%0d zen=1", e.cyc, e.a, e.b, e.z, e.bank));
            end
        end
        if (wrEn) begin
            if (wrQ.size() == 0) check("wr_extra", 1'b0, $sformatf("write at cyc=%0d A=%0d", cyc, wrA), "no write");
            else begin
                e = wrQ.pop_front();
                check("wr", e.cyc == cyc && wrA == e.a && wrB == e.b && wrBank == e.bank,
                      $sformatf("cyc=%0d A=%0d B=%0d bank=%0d", cyc, wrA, wrB, wrBank),
                      $sformatf("cyc=%0d A=%0d B=%0d bank=%0d", e.cyc, e.a, e.b, e.bank));
            end
        end
        if (done) begin
            if (dnQ.size() == 0) check("done_extra", 1'b0, $sformatf("DONE at cyc=%0d", cyc), "no DONE");
            else begin
                dn = dnQ.pop_front();
                check("done", dn.cyc == cyc && err == dn.err && !busy && (dn.res < 0 || resBank == dn.res),
                      $sformatf("cyc=%0d err=%0d busy=%0d res=%0d", cyc, err, busy, resBank),
                      $sformatf("cyc=%0d err=%0d busy=0 res=%0d", dn.cyc, dn.err, dn.res));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller sits 1 time unit after a posedge; START is sampled at the next edge (relative cycle 0).
    task automatic launch(input bit s, input int d, input int hAt, input int hLen, input int cut, input bit expBusy);
        int t0, n;
        sel   = s;
        depth = 4'(d);
        start = 1'b1;
        t0    = cyc + 1;
        pushModel(t0, s, d, hAt, hLen, cut);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = (hLen > 0) ? hAt + hLen : 1;
        for (int i = 0; i < n; i++) begin
            hold = (hLen > 0) && (cyc + 1 - t0 >= hAt) && (cyc + 1 - t0 < hAt + hLen);
            @(posedge clk);
            #1;
            if (cyc == t0 + 1)
                check("busy_start", busy == expBusy, $sformatf("busy=%0d", busy), $sformatf("busy=%0d", expBusy));
        end
        hold   = 1'b0;
        lastT0 = t0;
    endtask

    task automatic waitDone(input string nm, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check(nm, got, "DONE not seen", $sformatf("DONE within %0d cycles", budget));
    endtask

    task automatic checkDrained(input string nm);
        check(nm, rdQ.size() == 0 && wrQ.size() == 0 && dnQ.size() == 0 && spQ.size() == 0,
              $sformatf("pending rd=%0d wr=%0d done=%0d spot=%0d", rdQ.size(), wrQ.size(), dnQ.size(), spQ.size()),
              "all consumed");
    endtask

    task automatic checkAllZero(input string nm);
        logic [AW*5+9:0] v;
        v = {busy, done, err, rdEn, rdA, rdB, rdBank, zEn, zAddr, wrEn, wrA, wrB, wrBank, resBank};
        check(nm, v == '0, $sformatf("outputs=%0h", v), "all zero");
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; hold = 1'b0; depth = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset_state");
        rst = 1'b0;
        idle(2);

        // Forward, D=4
        t = cyc + 1;
        addSpot(t + 1, 0, 0, 8, 0, 0);
        addSpot(t + 5, 1, 0, 8, -1, 1);
        addSpot(t + 8, 0, 7, 15, -1, 0);
        addSpot(t + 13, 0, 0, 4, 1, 1);
        addSpot(t + 17, 0, 8, 12, 2, 1);
        launch(1'b0, 4, 0, 0, BIG, 1'b1);
        waitDone("fwd_d4_done", 200);
        idle(2);
        checkDrained("fwd_d4_drained");

        // Inverse, D=4
        t = cyc + 1;
        addSpot(t + 4, 0, 6, 7, 11, 0);
        addSpot(t + 13, 0, 0, 2, 6, 1);
        addSpot(t + 37, 0, 0, 8, 0, 1);
        launch(1'b1, 4, 0, 0, BIG, 1'b1);
        waitDone("inv_d4_done", 200);
        idle(2);
        checkDrained("inv_d4_drained");

        // Forward, D=3
        launch(1'b0, 3, 0, 0, BIG, 1'b1);
        waitDone("fwd_d3_done", 200);
        idle(2);
        checkDrained("fwd_d3_drained");

        // Illegal depths
        launch(1'b0, 0, 0, 0, BIG, 1'b0);
        waitDone("d0_done", 10);
        idle(6);
        checkDrained("d0_drained");
        launch(1'b0, 5, 0, 0, BIG, 1'b0);
        waitDone("d5_done", 10);
        idle(6);
        checkDrained("d5_drained");

        // Hold on cycles 3-4 of stage 0
        t = cyc + 1;
        addSpot(t + 5, 0, 2, 10, 0, 0);
        addSpot(t + 9, 1, 2, 10, -1, 1);
        launch(1'b0, 4, 3, 2, BIG, 1'b1);
        waitDone("hold_done", 200);
        idle(2);
        checkDrained("hold_drained");

        // START during the DONE cycle is ignored; accepted one cycle later
        launch(1'b0, 1, 0, 0, BIG, 1'b1);
        waitDone("d1_done", 50);
        start = 1'b1;
        @(posedge clk);
        #1;
        launch(1'b0, 1, 0, 0, BIG, 1'b1);
        waitDone("restart_done", 50);
        idle(2);
        checkDrained("restart_drained");

        // START and ABORT together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        idle(5);
        check("start_abort_idle", !busy && !rdEn, $sformatf("busy=%0d rd=%0d", busy, rdEn), "busy=0 rd=0");

        // ABORT at cycle 20, new START at cycle 25
        launch(1'b0, 4, 0, 0, 20, 1'b1);
        t = lastT0;
        while (cyc < t + 19) idle(1);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        for (int c = 21; c <= 24; c++) begin
            idle(1);
            check("abort_quiet", {rdEn, wrEn, busy, done} == 4'b0,
                  $sformatf("cyc=%0d rd=%0d wr=%0d busy=%0d done=%0d", c, rdEn, wrEn, busy, done), "all 0");
        end
        checkDrained("abort_drained");
        launch(1'b0, 1, 0, 0, BIG, 1'b1);
        check("post_abort_t0", lastT0 == t + 25, $sformatf("start edge %0d", lastT0 - t), "start edge 25");
        waitDone("post_abort_done", 50);
        idle(2);
        checkDrained("post_abort_drained");

        // Reset in the middle of stage 0
        launch(1'b1, 4, 0, 0, 10, 1'b1);
        t = lastT0;
        while (cyc < t + 9) idle(1);
        rst = 1'b1;
        idle(1);
        checkAllZero("mid_reset_outputs");
        rst = 1'b0;
        idle(25);
        checkDrained("mid_reset_drained");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/mdl_ntt_seq_ctrl.md
Name: mdl_ntt_seq_ctrl

Overview:
- Parametrised NTT/INTT sequencing controller for one radix-2 butterfly unit with a fixed pipeline latency.
- Generates read addresses, zeta ROM addresses, write-back addresses and ping-pong bank selects for a two-bank coefficient memory.
- Supports any power-of-two transform size, any butterfly latency, a runtime-programmable stage count, issue stalls and abort.
- Datapath muxing stays outside; this block drives addresses, enables and bank selects only.

Parameters:
PRM_COEFFS, 256, transform size N; power of two, N >= 4
PRM_ADDR, 12, coefficient and zeta address width; 2^PRM_ADDR >= N
PRM_LAT, 12, cycles from oRD_EN to the matching oWR_EN; range 1..63
PRM_LOGCO, clog2(PRM_COEFFS), maximum stage count (derived)

Ports:
iSYS_CLK  in  1  clock
iSYS_RST  in  1  synchronous reset, active-high
iFSM_START  in  1  start pulse; sampled only in IDLE
iFSM_ABORT  in  1  abort; highest priority after reset
iCTL_SEL  in  1  0 = forward (DIT), 1 = inverse (DIF); latched at start
iCTL_NTTDepth  in  4  stage count D; latched at start
iHOLD  in  1  suppresses read issue this cycle
oFSM_BUSY  out  1  high from the cycle after an accepted start until DONE
oFSM_DONE  out  1  one-cycle completion pulse
oFSM_ERR  out  1  valid with DONE; 1 = illegal depth
oRD_EN  out  1  read issue strobe
oRD_ADDRA, oRD_ADDRB  out  PRM_ADDR each  butterfly operand addresses
oRD_BANK  out  1  bank read this stage; 0 = B1, 1 = B2
oZeta_en  out  1  equals oRD_EN
oZeta_addr  out  PRM_ADDR  zeta ROM index, aligned with oRD_EN
oWR_EN  out  1  write-back strobe
oWR_ADDRA, oWR_ADDRB  out  PRM_ADDR each  write-back addresses
oWR_BANK  out  1  always ~oRD_BANK
oRES_BANK  out  1  bank holding the result; valid at DONE

Behaviour:
- All outputs are registered. Reset and abort clear every output to 0, clear the delay line and enter IDLE; no DONE is generated.
- States:
  - IDLE: START with D in 1..PRM_LOGCO moves to ISSUE at stage s = 0, bank 0. START with D = 0 or D > PRM_LOGCO moves to DONE with ERR = 1 and no memory activity. START while not in IDLE is ignored.
  - ISSUE: each cycle with iHOLD = 0 issues butterfly j (0..N/2-1) of stage s. After j = N/2-1 is issued, move to DRAIN.
  - DRAIN: wait until the last write of the stage has been issued. Then flip oRD_BANK. If s = D-1, move to DONE; otherwise increment s and return to ISSUE.
  - DONE: DONE = 1 for one cycle, BUSY = 0 in the same cycle, oRES_BANK = D[0]. Then move to IDLE.
- Address mapping:
  - Forward: len = N/2 >> s. Inverse: len = 1 << s.
  - g = j / len, k = j mod len.
  - A = 2·len·g + k, B = A + len.
  - Zeta index, forward: 2^s − 1 + g.
  - Zeta index, inverse: N/2^s − 2 − g.
- Write-back is a PRM_LAT-deep delay line of {valid, A, B} fed by the read issue:
  - oWR_EN/ADDR at cycle t+PRM_LAT mirror oRD_EN/ADDR at cycle t.
  - iHOLD inserts bubbles; the delay line keeps shifting.
- Timing with no holds:
  - Accepted START at cycle 0; first oRD_EN at cycle 1.
  - Stage s first read at cycle 1 + s·(N/2 + PRM_LAT).
  - DONE at cycle D·(N/2 + PRM_LAT) + 1.
  - Each hold cycle delays everything after it by one cycle.
- Boundaries:
  - A hold on the final issue cycle extends ISSUE.
  - START and ABORT in the same cycle: ABORT wins.
  - START in the same cycle as DONE is ignored; START is accepted again from the following cycle.
  - Counters never wrap past N/2 − 1 or D − 1.

Test Plan:
- N=16, LAT=4, SEL=0, D=4, no hold.
  - Cycle 1: RD A=0, B=8, zeta 0, bank 0.
  - Cycle 8: A=7, B=15.
  - Cycle 5: WR A=0, B=8, WR_BANK 1.
  - Cycle 13: stage-1 first read A=0, B=4, zeta 1, RD_BANK 1.
  - Stage 1, j=4: A=8, B=12, zeta 2.
  - DONE at cycle 49, RES_BANK 0.
- Same configuration with SEL=1.
  - Stage 0, j=3: A=6, B=7, zeta 11.
  - Stage 1 first read: A=0, B=2, zeta 6.
  - Last stage (s=3): A=0, B=8, zeta 0.
- D=3, forward: DONE at cycle 37, RES_BANK 1, ERR 0. D=0: DONE at cycle 1, ERR 1. D=5: DONE with ERR 1. Neither illegal case ever asserts RD_EN or WR_EN.
- iHOLD high on cycles 3–4 of stage 0: j=2 issued at cycle 5; write for j=2 at cycle 9; WR_EN low at cycles 7–8; DONE at cycle 51.
- ABORT at cycle 20: all strobes 0 and BUSY 0 from cycle 21; no DONE; a new START at cycle 25 produces its first read at cycle 26 at A=0, B=8.
- Reset asserted mid-stage: every output is 0 on the next cycle and the delay line is empty, so no stray WR_EN appears afterwards.
